// File: rtl/besthop_select.sv
// besthop_select: scans the neighbour Q-table and reports the highest-Q neighbour (index, node ID and Q-value).
// Epsilon-greedy exploration is compiled in when BESTHOP_EXPLORE_EN is defined.
module besthop_select #(
  parameter int MAX_NEIGHBORS = 32
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data_in,
  output logic [10:0] address,
  output logic [15:0] besthop,
  output logic [15:0] action,
  output logic [15:0] best_q,
  output logic        no_route,
  output logic        explored,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, CNT_A, CNT_L, Q_A, Q_L, ID_A, ID_L, DONE} state_t;
  state_t state, next;
  logic [6:0] n, n_in, i, best, best_nx, win;
  logic [15:0] q_nx, win_q;
  logic take, last;
  assign n_in = data_in > 16'(MAX_NEIGHBORS) ? 7'(MAX_NEIGHBORS) : data_in[6:0];
  assign take = i == 7'd0 || data_in > best_q;
  assign best_nx = take ? i : best;
  assign q_nx = take ? data_in : best_q;
  assign last = i == n - 7'd1;
`ifdef BESTHOP_EXPLORE_EN
  logic [15:0] lfsr, qr;
  logic [5:0] r;
  logic expl;
  assign win = expl ? 7'(r) : best_nx;
  assign win_q = expl ? (i == 7'(r) ? data_in : qr) : q_nx;
  always_ff @(posedge clock)
    if (rst) begin
      lfsr <= 16'hACE1;
      qr <= '0;
      r <= '0;
      expl <= 1'b0;
      explored <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (state == CNT_L) begin
        expl <= n_in != 7'd0 && lfsr[3:0] == 4'd0;
        r <= 7'(lfsr[9:4]) >= n_in ? 6'd0 : lfsr[9:4];
        explored <= 1'b0;
      end
      if (state == Q_L && i == 7'(r)) qr <= data_in;
      if (state == Q_L && last) explored <= expl;
    end
`else
  assign win = best_nx;
  assign win_q = q_nx;
  assign explored = 1'b0;
`endif
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? CNT_A : IDLE;
      CNT_A:   next = CNT_L;
      CNT_L:   next = n_in == 7'd0 ? DONE : Q_A;
      Q_A:     next = Q_L;
      Q_L:     next = last ? ID_A : Q_A;
      ID_A:    next = ID_L;
      ID_L:    next = DONE;
      DONE:    next = start ? DONE : IDLE;
      default: next = IDLE;
    endcase
  end
  // address is loaded on entry to each *_A state so read data arrives in the matching *_L state
  always_ff @(posedge clock)
    if (rst) begin
      state <= IDLE;
      address <= '0;
      besthop <= '0;
      action <= '0;
      best_q <= '0;
      no_route <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      n <= '0;
      i <= '0;
      best <= '0;
    end else begin
      state <= next;
      busy <= next != IDLE && next != DONE;
      done <= next == DONE;
      case (state)
        IDLE: if (start) address <= 11'h046;
        CNT_L: begin
          n <= n_in;
          i <= '0;
          best <= '0;
          best_q <= '0;
          no_route <= n_in == 7'd0;
          if (n_in == 7'd0) begin
            besthop <= 16'hFFFF;
            action <= 16'hFFFF;
          end else address <= 11'h0C8;
        end
        Q_L: begin
          i <= i + 7'd1;
          best <= last ? win : best_nx;
          best_q <= last ? win_q : q_nx;
          address <= last ? 11'h048 + 11'({win, 1'b0}) : 11'h0C8 + 11'({i + 7'd1, 1'b0});
        end
        ID_L: begin
          besthop <= data_in;
          action <= 16'(best);
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_besthop_select.sv
// tb_besthop_select: randomized and directed checks of besthop_select against an argmax reference model.
module tb_besthop_select;
  localparam int MAXN = 32;
  logic clock = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [15:0] data_in;
  logic [10:0] address;
  logic [15:0] besthop, action, best_q;
  logic no_route, explored, busy, done;
  logic [15:0] mem [0:2047];
  int total = 0;
  int bad = 0;

  besthop_select #(.MAX_NEIGHBORS(MAXN)) dut (
    .clock(clock), .rst(rst), .start(start), .data_in(data_in), .address(address),
    .besthop(besthop), .action(action), .best_q(best_q), .no_route(no_route),
    .explored(explored), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) data_in <= mem[address];

  task automatic clear_mem();
    for (int k = 0; k < 2048; k++) mem[k] = 16'd0;
  endtask

  task automatic set_entry(input int k, input int q, input int id);
    mem[(200 + 2 * k) % 2048] = 16'(q);
    mem[(72 + 2 * k) % 2048] = 16'(id);
  endtask

  function automatic void model(output logic [15:0] e_hop, output logic [15:0] e_act,
                                output logic [15:0] e_q, output logic e_nr,
                                output int e_lat, output int e_qmax);
    int n, b;
    n = int'(mem[70]) > MAXN ? MAXN : int'(mem[70]);
    b = 0;
    if (n == 0) begin
      e_hop = 16'hFFFF; e_act = 16'hFFFF; e_q = 16'd0; e_nr = 1'b1; e_lat = 2; e_qmax = -1;
      return;
    end
    for (int k = 1; k < n; k++) if (mem[200 + 2 * k] > mem[200 + 2 * b]) b = k;
    e_hop = mem[72 + 2 * b];
    e_act = 16'(b);
    e_q = mem[200 + 2 * b];
    e_nr = 1'b0;
    e_lat = 2 * n + 4;
    e_qmax = 200 + 2 * (n - 1);
  endfunction

  task automatic do_run(output int lat, output int bcnt, output int qmax, output bit held, output bit idle_ok);
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1;
    lat = 0;
    bcnt = busy ? 1 : 0;
    qmax = -1;
    while (!done && lat < 500) begin
      @(posedge clock); #1;
      lat++;
      if (busy) bcnt++;
      if (address >= 11'd200 && int'(address) > qmax) qmax = int'(address);
    end
    repeat (3) @(posedge clock);
    #1 held = done;
    @(negedge clock); start = 1'b0;
    @(posedge clock); #1;
    idle_ok = !done && !busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({address, besthop, action, best_q} !== 59'd0) begin
      bad++; $display("FAIL reset_data got %h want 0", {address, besthop, action, best_q});
    end
    total++;
    if ({no_route, explored, busy, done} !== 4'd0) begin
      bad++; $display("FAIL reset_flags got %b want 0000", {no_route, explored, busy, done});
    end
    @(negedge clock); rst = 1'b0;
  endtask

  task automatic test_greedy();
    logic [15:0] e_hop, e_act, e_q;
    logic e_nr;
    int e_lat, e_qmax, lat, bcnt, qmax;
    bit held, idle_ok;
    for (int c = 0; c < 4; c++) begin
      clear_mem();
      case (c)
        0: begin
          mem[70] = 16'd4;
          set_entry(0, 10, 7); set_entry(1, 50, 9); set_entry(2, 30, 3); set_entry(3, 20, 5);
        end
        1: begin
          mem[70] = 16'd3;
          set_entry(0, 40, 11); set_entry(1, 40, 22); set_entry(2, 12, 33);
        end
        2: mem[70] = 16'd0;
        default: begin
          mem[70] = 16'd100;
          for (int k = 0; k < 64; k++) set_entry(k, $urandom_range(0, 999), $urandom_range(0, 65535));
          set_entry(40, 60000, 1234);
        end
      endcase
      model(e_hop, e_act, e_q, e_nr, e_lat, e_qmax);
      do_run(lat, bcnt, qmax, held, idle_ok);
      total++; if (lat !== e_lat) begin bad++; $display("FAIL greedy%0d latency got %0d want %0d", c, lat, e_lat); end
      total++; if (bcnt !== e_lat) begin bad++; $display("FAIL greedy%0d busy_cycles got %0d want %0d", c, bcnt, e_lat); end
      total++; if (qmax !== e_qmax) begin bad++; $display("FAIL greedy%0d last_q_addr got %0d want %0d", c, qmax, e_qmax); end
      total++; if (action !== e_act) begin bad++; $display("FAIL greedy%0d action got %h want %h", c, action, e_act); end
      total++; if (besthop !== e_hop) begin bad++; $display("FAIL greedy%0d besthop got %h want %h", c, besthop, e_hop); end
      total++; if (best_q !== e_q) begin bad++; $display("FAIL greedy%0d best_q got %h want %h", c, best_q, e_q); end
      total++; if (no_route !== e_nr) begin bad++; $display("FAIL greedy%0d no_route got %b want %b", c, no_route, e_nr); end
      total++; if (explored !== 1'b0) begin bad++; $display("FAIL greedy%0d explored got %b want 0", c, explored); end
      total++; if (held !== 1'b1) begin bad++; $display("FAIL greedy%0d done_hold got %b want 1", c, held); end
      total++; if (idle_ok !== 1'b1) begin bad++; $display("FAIL greedy%0d idle_after got %b want 1", c, idle_ok); end
    end
  endtask

  task automatic test_random();
    logic [15:0] e_hop, e_act, e_q;
    logic e_nr;
    int e_lat, e_qmax, lat, bcnt, qmax;
    bit held, idle_ok;
    for (int t = 0; t < 25; t++) begin
      clear_mem();
      mem[70] = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
      for (int k = 0; k < 64; k++) set_entry(k, $urandom_range(0, 15), $urandom_range(0, 65535));
      model(e_hop, e_act, e_q, e_nr, e_lat, e_qmax);
      do_run(lat, bcnt, qmax, held, idle_ok);
      total++; if (lat !== e_lat) begin bad++; $display("FAIL rand%0d latency got %0d want %0d", t, lat, e_lat); end
      total++; if (qmax !== e_qmax) begin bad++; $display("FAIL rand%0d last_q_addr got %0d want %0d", t, qmax, e_qmax); end
      total++;
      if ({action, besthop, best_q, no_route} !== {e_act, e_hop, e_q, e_nr}) begin
        bad++;
        $display("FAIL rand%0d result got act=%h hop=%h q=%h nr=%b want act=%h hop=%h q=%h nr=%b",
                 t, action, besthop, best_q, no_route, e_act, e_hop, e_q, e_nr);
      end
      total++; if (idle_ok !== 1'b1) begin bad++; $display("FAIL rand%0d idle_after got %b want 1", t, idle_ok); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e_hop, e_act, e_q;
    logic e_nr;
    int e_lat, e_qmax, lat, bcnt, qmax;
    bit held, idle_ok;
    clear_mem();
    mem[70] = 16'd5;
    for (int k = 0; k < 5; k++) set_entry(k, $urandom_range(0, 65535), $urandom_range(0, 65535));
    @(negedge clock); start = 1'b1;
    @(posedge clock);
    repeat (7) @(posedge clock);
    #1;
    total++; if (address !== 11'd204) begin bad++; $display("FAIL midrst q_l2_addr got %h want %h", address, 11'd204); end
    rst = 1'b1; start = 1'b0;
    @(posedge clock); #1;
    total++;
    if ({address, besthop, action, best_q, no_route, explored, busy, done} !== 63'd0) begin
      bad++; $display("FAIL midrst outputs got %h want 0", {address, besthop, action, best_q, no_route, explored, busy, done});
    end
    @(negedge clock); rst = 1'b0;
    model(e_hop, e_act, e_q, e_nr, e_lat, e_qmax);
    do_run(lat, bcnt, qmax, held, idle_ok);
    total++; if (lat !== e_lat) begin bad++; $display("FAIL midrst latency got %0d want %0d", lat, e_lat); end
    total++;
    if ({action, besthop, best_q} !== {e_act, e_hop, e_q}) begin
      bad++; $display("FAIL midrst result got %h/%h/%h want %h/%h/%h", action, besthop, best_q, e_act, e_hop, e_q);
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_greedy();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/besthop_select.md
# besthop_select

Upstream of the reward stage in the Q-routing node datapath. On `start`, it scans the node's neighbour Q-value table in shared data memory and selects the neighbour with the highest Q-value. It then reads that neighbour's node ID and presents `action` (table index) and `besthop` (neighbour node ID), which the reward stage consumes. A one-word neighbour count in memory bounds the scan.

## Interface
Parameters:
- `MAX_NEIGHBORS`, 32: upper bound on scanned entries; the stored count is clipped to this value. Legal range 1..64.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level request; sampled only in IDLE.
- `data_in`  in  16  memory read data, valid the cycle after `address` is presented.
- `address`  out  11  registered memory word address (byte-style, step 2).
- `besthop`  out  16  selected neighbour node ID.
- `action`  out  16  selected neighbour index (zero-extended).
- `best_q`  out  16  Q-value of the selected neighbour.
- `no_route`  out  1  count was 0; no selection made.
- `explored`  out  1  selection came from exploration (only when EXPLORE_EN is defined; otherwise tied 0).
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  result valid.

## Operation
- Memory map: count at 11'h046; neighbour IDs at 11'h048 + i*2; Q-values at 11'h0C8 + i*2. Addresses are computed in 11 bits and truncate on overflow.
- N = min(mem[11'h046], MAX_NEIGHBORS). Q-values are unsigned 16-bit.
- States and transitions:
  - IDLE: if `start`, go to CNT_A.
  - CNT_A: `address` = 11'h046; go to CNT_L.
  - CNT_L: latch N and clear the scan registers (i=0, best=0, best_q=0). If N=0, set `no_route`=1, `besthop`=16'hFFFF, `action`=16'hFFFF, and go to DONE. Otherwise go to Q_A.
  - Q_A: `address` = 11'h0C8 + i*2; go to Q_L.
  - Q_L: compare `data_in`. Update best/best_q if i==0 or `data_in` > best_q (strict, so ties keep the lowest index). Increment i. If i==N-1, go to ID_A; else go to Q_A.
  - ID_A: `address` = 11'h048 + best*2; go to ID_L.
  - ID_L: `besthop` = `data_in`; `action` = best; go to DONE.
  - DONE: `done`=1. Return to IDLE when `start` is low. On leaving DONE, clear `done`. Results hold until the next CNT_L.
- `start` is ignored while busy or in DONE while still high; there is no retrigger.
- `address` holds its last value in states that do not drive it.

## Timing
- Reset: state IDLE. `address`, `besthop`, `action`, `best_q` are all 0; `no_route`, `explored`, `busy`, `done` are 0. The LFSR is set to 16'hACE1.
- Reset mid-scan returns to IDLE on the same edge and discards partial results.
- Memory read latency is fixed at 1 cycle; there is no wait handshake.
- Latency from the edge that samples `start` to `done` high:
  - N>=1: 2N+4 edges.
  - N=0: 2 edges.
- Per-neighbour throughput is 2 cycles.
- `done` and `no_route` are registered outputs. There are no combinational paths from inputs to outputs.

## Configuration
- `BESTHOP_EXPLORE_EN` defined: epsilon-greedy exploration is compiled in.
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) advances every cycle.
  - In CNT_L with N>0, if lfsr[3:0]==0, latch an explore flag and a random index r = lfsr[9:4]; if r >= N, use r = 0.
  - The scan runs unchanged, with identical timing, and also captures Q[r] when i==r.
  - At ID_A the scan winner is replaced by r, `best_q` by Q[r], and `explored` is set to 1. `explored` is cleared in CNT_L.
- Undefined: no LFSR is built, `explored` is tied 0, and selection is always greedy.

## Test plan
- Count=4, Q={10,50,30,20}, IDs={7,9,3,5} -> `action`=1, `besthop`=9, `best_q`=50, `done` 12 edges after start.
- Count=3, Q={40,40,12} -> tie goes to the lowest index: `action`=0, `best_q`=40.
- Count=0 -> `no_route`=1, `besthop`=16'hFFFF, `action`=16'hFFFF, `done` 2 edges after start, no reads at 11'h0C8+.
- Count=100 with MAX_NEIGHBORS=32 and the maximum Q stored at index 40 -> scan stops at index 31 and the selection is the best of 0..31; last Q address 11'h106.
- `rst` pulsed during Q_L of i=2 -> next cycle IDLE with all outputs 0; a new start completes normally.
- With BESTHOP_EXPLORE_EN: force/seed the LFSR so lfsr[3:0]==0 and lfsr[9:4]=2 at CNT_L, count=4 -> `action`=2, `explored`=1, latency still 12; the next greedy run clears `explored`.
